exu_ldst_mem_bridge: RTL and testbench

Downstream partner of the EXU load/store handler. Accepts one `ldst_req` packet at a time and converts it into a single word access on the data-memory port. It shifts store data and byte strobes into the correct byte lanes and right-aligns load data. It then returns a `ldst_rsp` packet for every request, loads and stores alike. Misaligned stores are rejected without touching memory and are flagged on a dedicated error pulse.

---
 rtl/exu_ldst_mem_bridge_if.sv | 30 +++
 rtl/exu_ldst_mem_bridge.sv | 116 +++++++++++
 tb/tb_exu_ldst_mem_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_ldst_mem_bridge_if.sv
// Handshake channels between the EXU load/store handler and the data-memory bridge.
// The request carries a full ldst packet; the response returns the right-aligned word.
interface ldst_req_if_t;
    typedef struct packed {
        logic [31:0] addr;
        logic        st;
        logic [31:0] data;
        logic [3:0]  strobe;
    } pkt_t;

    logic vld;
    logic rdy;
    pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface ldst_rsp_if_t;
    typedef struct packed {
        logic [31:0] data;
    } pkt_t;

    logic vld;
    logic rdy;
    pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/exu_ldst_mem_bridge.sv
// Converts one ldst request at a time into a single word access on the data-memory port,
// lane-shifting store data/strobes and right-aligning load data into the response.
module exu_ldst_mem_bridge #(
    parameter int unsigned MEM_AW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ldst_req_if_t.slv         ldst_req_slv,
    ldst_rsp_if_t.mst         ldst_rsp_mst,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvld,
    input  logic [31:0]       mem_rdata,
    output logic              misalign_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

    state_e            state_q, state_d;
    logic              req_hs;
    logic [1:0]        off, off_q;
    logic [7:0]        be8;
    logic              misaligned;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rsp_data_q;
    logic              misalign_err_q;

    assign off        = ldst_req_slv.pkt.addr[1:0];
    assign be8        = {4'b0000, ldst_req_slv.pkt.strobe} << off;
    // Only stores can spill into the next word; loads always read the full word.
    assign misaligned = ldst_req_slv.pkt.st && (be8[7:4] != 4'b0000);
    assign req_hs     = ldst_req_slv.vld && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ldst_req_slv.vld) begin
                    state_d = misaligned ? StRsp : StReq;
                end
            end
            StReq: begin
                if (mem_gnt) state_d = StWait;
            end
            StWait: begin
                if (mem_rvld) state_d = StRsp;
            end
            StRsp: begin
                if (ldst_rsp_mst.rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ldst_req_slv.rdy = 1'b0;
        ldst_rsp_mst.vld = 1'b0;
        mem_req          = 1'b0;
        unique case (state_q)
            StIdle:  ldst_req_slv.rdy = 1'b1;
            StReq:   mem_req          = 1'b1;
            StWait:  ;
            StRsp:   ldst_rsp_mst.vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q          <= 2'b00;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= 4'b0000;
            mem_wdata_q    <= 32'h0;
            rsp_data_q     <= 32'h0;
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= req_hs && misaligned;
            if (req_hs) begin
                off_q       <= off;
                mem_we_q    <= ldst_req_slv.pkt.st;
                mem_addr_q  <= {ldst_req_slv.pkt.addr[MEM_AW-1:2], 2'b00};
                mem_be_q    <= ldst_req_slv.pkt.st ? be8[3:0] : 4'b1111;
                mem_wdata_q <= ldst_req_slv.pkt.data << {off, 3'b000};
            end
            if (req_hs && misaligned) begin
                rsp_data_q <= 32'h0;
            end else if ((state_q == StWait) && mem_rvld) begin
                rsp_data_q <= mem_we_q ? 32'h0 : (mem_rdata >> {off_q, 3'b000});
            end
        end
    end

    assign mem_we                = mem_we_q;
    assign mem_addr              = mem_addr_q;
    assign mem_be                = mem_be_q;
    assign mem_wdata             = mem_wdata_q;
    assign misalign_err          = misalign_err_q;
    assign ldst_rsp_mst.pkt.data = rsp_data_q;

endmodule

// File: tb/tb_exu_ldst_mem_bridge.sv
// Scoreboard bench: a byte-level memory model predicts every memory access and response,
// a monitor compares them as the bridge presents them.
module tb_exu_ldst_mem_bridge;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          t_hs;
        int          exp_lat;
    } rsp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_req, mem_gnt, mem_we, mem_rvld, misalign_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    ldst_req_if_t req_if ();
    ldst_rsp_if_t rsp_if ();

    exu_ldst_mem_bridge #(.MEM_AW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ldst_req_slv (req_if),
        .ldst_rsp_mst (rsp_if),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvld     (mem_rvld),
        .mem_rdata    (mem_rdata),
        .misalign_err (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rsp_exp_t    rsp_q[$];
    mem_exp_t    mem_q[$];
    logic [7:0]  ref_mem[int unsigned];
    logic [31:0] phys[int unsigned];

    int n_chk = 0;
    int n_fail = 0;
    bit done = 0;
    int gnt_stall, rvld_dly, rdy_mode, hold_left;
    bit outstanding = 0;

    function automatic logic [7:0] ref_byte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        phys[a >> 2] = w;
        for (int j = 0; j < 4; j++) ref_mem[{a[31:2], 2'b00} + j] = w[8*j +: 8];
    endtask

    // Reference model: byte-granular memory, access size from the strobe width.
    task automatic issue(input logic [31:0] addr, input logic st, input logic [31:0] data,
                         input logic [3:0] strobe, input int lat);
        int unsigned off, size, word;
        bit          mis;
        rsp_exp_t    r;
        mem_exp_t    m;
        int          guard;
        off  = addr[1:0];
        word = {addr[31:2], 2'b00};
        size = (strobe == 4'b1111) ? 4 : (strobe == 4'b0011) ? 2 : 1;
        mis  = st && (off + size > 4);
        r.err = mis;
        r.data = 32'h0;
        r.exp_lat = lat;
        m.we = st;
        m.addr = word;
        m.be = st ? 4'b0000 : 4'b1111;
        m.wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(off)) m.wdata[8*k +: 8] = data[8*(k-int'(off)) +: 8];
        end
        if (st && !mis) begin
            for (int j = 0; j < int'(size); j++) begin
                m.be[off + j] = 1'b1;
                ref_mem[addr + j] = data[8*j +: 8];
            end
        end else if (!st) begin
            for (int j = 0; j < 4; j++) begin
                if (int'(off) + j < 4) r.data[8*j +: 8] = ref_byte(word + off + j);
            end
        end
        @(posedge clk);
        #1;
        req_if.vld = 1'b1;
        req_if.pkt.addr = addr;
        req_if.pkt.st = st;
        req_if.pkt.data = data;
        req_if.pkt.strobe = strobe;
        guard = 0;
        while (!req_if.rdy) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                $display("FAIL req_handshake_timeout: rdy=%0b required 1", req_if.rdy);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        req_if.vld = 1'b0;
        r.t_hs = cyc - 1;
        rsp_q.push_back(r);
        if (!mis) mem_q.push_back(m);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (rsp_q.size() == 0 && !outstanding && !rsp_if.vld && !mem_req) break;
        end
    endtask

    // Memory responder.
    initial begin
        int          stall_left, rvld_left;
        bit          in_req;
        logic [31:0] rd_word, w;
        int unsigned k;
        mem_gnt = 1'b0;
        mem_rvld = 1'b0;
        mem_rdata = 32'h0;
        in_req = 0;
        stall_left = 0;
        rvld_left = 0;
        rd_word = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvld = 1'b0;
            mem_rdata = $urandom();
            if (outstanding) begin
                rvld_left--;
                if (rvld_left <= 0) begin
                    mem_rvld = 1'b1;
                    mem_rdata = rd_word;
                    outstanding = 0;
                end
            end else if (mem_req) begin
                if (!in_req) begin
                    in_req = 1;
                    stall_left = (gnt_stall < 0) ? int'($urandom_range(0, 3)) : gnt_stall;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_gnt = 1'b1;
                    in_req = 0;
                    outstanding = 1;
                    rvld_left = (rvld_dly < 0) ? int'($urandom_range(1, 3)) : rvld_dly;
                    k = mem_addr >> 2;
                    w = phys.exists(k) ? phys[k] : 32'h0;
                    if (mem_we) begin
                        for (int j = 0; j < 4; j++) if (mem_be[j]) w[8*j +: 8] = mem_wdata[8*j +: 8];
                        phys[k] = w;
                    end
                    rd_word = w;
                end
            end
        end
    end

    // Response ready driver.
    initial begin
        rsp_if.rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: rsp_if.rdy = 1'b1;
                1: rsp_if.rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (rsp_if.vld && hold_left > 0) begin
                        rsp_if.rdy = 1'b0;
                        hold_left--;
                    end else begin
                        rsp_if.rdy = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        bit          mreq_p, mgnt_p, rvld_p, rrdy_p;
        logic [68:0] mfields;
        logic [31:0] rsp_saved;
        mem_exp_t    e;
        rsp_exp_t    h;
        mreq_p = 0; mgnt_p = 0; rvld_p = 0; rrdy_p = 0;
        mfields = '0;
        rsp_saved = 32'h0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!rst_n) begin
                rsp_q.delete();
                mem_q.delete();
                mreq_p = 0; mgnt_p = 0; rvld_p = 0; rrdy_p = 0;
                chk(!mem_req && !mem_we && !misalign_err, "rst_ctrl",
                    {29'h0, mem_req, mem_we, misalign_err}, 32'h0);
                chk(mem_addr == 32'h0, "rst_mem_addr", mem_addr, 32'h0);
                chk(mem_be == 4'h0, "rst_mem_be", {28'h0, mem_be}, 32'h0);
                chk(mem_wdata == 32'h0, "rst_mem_wdata", mem_wdata, 32'h0);
                chk(req_if.rdy && !rsp_if.vld, "rst_handshake",
                    {30'h0, req_if.rdy, rsp_if.vld}, 32'h2);
                chk(rsp_if.pkt.data == 32'h0, "rst_rsp_data", rsp_if.pkt.data, 32'h0);
                continue;
            end
            chk(!(mem_gnt && mem_rvld), "gnt_rvld_overlap", {31'h0, mem_rvld}, 32'h0);
            chk(req_if.rdy == (rsp_q.size() == 0), "req_rdy",
                {31'h0, req_if.rdy}, {31'h0, rsp_q.size() == 0});
            if (mem_req) begin
                if (!(mreq_p && !mgnt_p)) begin
                    chk(mem_q.size() != 0, "unexpected_mem_req", mem_addr, 32'h0);
                    if (mem_q.size() != 0) begin
                        e = mem_q.pop_front();
                        chk(mem_we == e.we, "mem_we", {31'h0, mem_we}, {31'h0, e.we});
                        chk(mem_addr == e.addr, "mem_addr", mem_addr, e.addr);
                        chk(mem_be == e.be, "mem_be", {28'h0, mem_be}, {28'h0, e.be});
                        if (e.we) chk(mem_wdata == e.wdata, "mem_wdata", mem_wdata, e.wdata);
                    end
                    mfields = {mem_we, mem_addr, mem_be, mem_wdata};
                end else begin
                    chk({mem_we, mem_addr, mem_be, mem_wdata} == mfields, "mem_stable",
                        mem_addr, mfields[67:36]);
                end
            end
            if (rsp_if.vld) begin
                if (!(rvld_p && !rrdy_p)) begin
                    chk(rsp_q.size() != 0, "unexpected_rsp", rsp_if.pkt.data, 32'h0);
                    if (rsp_q.size() != 0) begin
                        h = rsp_q[0];
                        chk(rsp_if.pkt.data == h.data, "rsp_data", rsp_if.pkt.data, h.data);
                        chk(misalign_err == h.err, "misalign_err",
                            {31'h0, misalign_err}, {31'h0, h.err});
                        if (h.exp_lat != 0)
                            chk(cyc - h.t_hs == h.exp_lat, "rsp_latency",
                                32'(cyc - h.t_hs), 32'(h.exp_lat));
                    end
                    rsp_saved = rsp_if.pkt.data;
                end else begin
                    chk(rsp_if.pkt.data == rsp_saved, "rsp_stable", rsp_if.pkt.data, rsp_saved);
                    chk(!misalign_err, "err_pulse_len", {31'h0, misalign_err}, 32'h0);
                end
                if (rsp_if.rdy && rsp_q.size() != 0) void'(rsp_q.pop_front());
            end else begin
                chk(!misalign_err, "err_without_rsp", {31'h0, misalign_err}, 32'h0);
            end
            mreq_p = mem_req;
            mgnt_p = mem_gnt;
            rvld_p = rsp_if.vld;
            rrdy_p = rsp_if.rdy;
        end
        chk(rsp_q.size() == 0, "rsp_leftover", rsp_q.size(), 32'h0);
        chk(mem_q.size() == 0, "mem_leftover", mem_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Stimulus.
    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          guard;
        rst_n = 1'b0;
        req_if.vld = 1'b0;
        req_if.pkt = '0;
        rdy_mode = 0;
        gnt_stall = 0;
        rvld_dly = 1;
        hold_left = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        preload(32'h1004, 32'hDEAD_BEEF);
        issue(32'h0000_1004, 1'b0, 32'h5555_AAAA, 4'hF, 3);
        wait_idle();
        preload(32'h1004, 32'h8877_6655);
        issue(32'h0000_1007, 1'b0, 32'h0, 4'h1, 3);
        wait_idle();
        issue(32'h0000_200A, 1'b1, 32'h1234_ABCD, 4'h3, 3);
        wait_idle();
        issue(32'h0000_3001, 1'b1, 32'hCAFE_F00D, 4'hF, 1);
        wait_idle();

        gnt_stall = 5;
        rdy_mode = 2;
        hold_left = 3;
        issue(32'h0000_1008, 1'b0, 32'h0, 4'hF, 0);
        wait_idle();

        gnt_stall = -1;
        rvld_dly = -1;
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            a = 32'h1000 + $urandom_range(0, 31);
            case ($urandom_range(0, 2))
                0: s = 4'h1;
                1: s = 4'h3;
                default: s = 4'hF;
            endcase
            issue(a, 1'($urandom_range(0, 1)), $urandom(), s, 0);
        end
        wait_idle();

        rdy_mode = 0;
        gnt_stall = 0;
        rvld_dly = 6;
        issue(32'h0000_1010, 1'b0, 32'h0, 4'hF, 0);
        guard = 0;
        while (!outstanding && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rvld_dly = -1;
        guard = 0;
        while (outstanding && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        preload(32'h1014, 32'h0BAD_F00D);
        issue(32'h0000_1015, 1'b0, 32'h0, 4'h3, 0);
        wait_idle();
        repeat (2) @(posedge clk);
        done = 1;
    end

endmodule
